// File: rtl/mmio_host_initiator.sv
// mmio_host_initiator: host-side CCI-P MMIO initiator issuing c0 MMIO writes/reads and collecting c2 read responses.
// Optional statistics counters are compiled in when MMIO_INIT_STATS_EN is defined.

package ccip_if_pkg;
    typedef logic [15:0]  t_ccip_mmioAddr;
    typedef logic [8:0]   t_ccip_tid;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [63:0]  t_ccip_mmioData;
    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;
    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;
    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        t_ccip_clData        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;
    typedef struct packed {
        logic [27:0] hdr;
        logic        rspValid;
    } t_if_ccip_c1_Rx;
    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;
    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;
    typedef struct packed {
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;
endpackage

module mmio_host_initiator
    import ccip_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TID_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output t_if_ccip_Rx rx,
    input  t_if_ccip_Tx tx
`ifdef MMIO_INIT_STATS_EN
    ,
    output logic [31:0] stat_wr_cnt,
    output logic [31:0] stat_rd_cnt,
    output logic [15:0] stat_timeout_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, ISSUE_WR, ISSUE_RD, WAIT_RSP, DONE} t_state;

    t_state            r_state, w_next;
    logic              r_cmd_ready, r_rsp_valid, r_rsp_err, w_rsp_err;
    logic [63:0]       r_rsp_data, w_rsp_data;
    t_if_ccip_Rx       r_rx, w_rx;
    logic [TID_W-1:0]  r_tid;
    logic [15:0]       r_to;
    logic              w_match, w_to_end;

    assign w_match  = tx.c2.mmioRdValid && (tx.c2.hdr.tid == t_ccip_tid'(r_tid));
    assign w_to_end = r_to == 16'(TIMEOUT_CYCLES - 1);

    // Next state plus the next value of every registered output
    always_comb begin
        w_next     = r_state;
        w_rx       = '0;
        w_rsp_data = '0;
        w_rsp_err  = 1'b0;
        case (r_state)
            IDLE: if (cmd_valid && r_cmd_ready) begin
                w_next                 = cmd_write ? ISSUE_WR : ISSUE_RD;
                w_rx.c0.hdr.address    = cmd_addr;
                w_rx.c0.hdr.length     = 2'b01;
                w_rx.c0.hdr.tid        = t_ccip_tid'(r_tid);
                w_rx.c0.data           = cmd_write ? t_ccip_clData'(cmd_wdata) : '0;
                w_rx.c0.mmioWrValid    = cmd_write;
                w_rx.c0.mmioRdValid    = !cmd_write;
            end
            ISSUE_WR: w_next = DONE;
            ISSUE_RD: w_next = WAIT_RSP;
            WAIT_RSP: begin
                if (w_match) begin
                    w_next     = DONE;
                    w_rsp_data = tx.c2.data;
                end else if (w_to_end) begin
                    w_next    = DONE;
                    w_rsp_err = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    // Registered outputs, tid counter (advances once per completed or timed-out read) and timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rx        <= '0;
            r_tid       <= '0;
            r_to        <= '0;
        end else begin
            r_cmd_ready <= w_next == IDLE;
            r_rsp_valid <= w_next == DONE;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
            r_rx        <= w_rx;
            r_to        <= (r_state == WAIT_RSP) ? r_to + 16'd1 : '0;
            if (r_state == WAIT_RSP && w_next == DONE) r_tid <= r_tid + TID_W'(1);
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign rx        = r_rx;

`ifdef MMIO_INIT_STATS_EN
    logic [31:0] r_stat_wr, r_stat_rd;
    logic [15:0] r_stat_to;

    // Saturating activity counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_wr <= '0;
            r_stat_rd <= '0;
            r_stat_to <= '0;
        end else begin
            if (r_state == ISSUE_WR && r_stat_wr != '1) r_stat_wr <= r_stat_wr + 32'd1;
            if (r_state == ISSUE_RD && r_stat_rd != '1) r_stat_rd <= r_stat_rd + 32'd1;
            if (r_state == WAIT_RSP && !w_match && w_to_end && r_stat_to != '1) r_stat_to <= r_stat_to + 16'd1;
        end
    end

    assign stat_wr_cnt      = r_stat_wr;
    assign stat_rd_cnt      = r_stat_rd;
    assign stat_timeout_cnt = r_stat_to;
`endif
endmodule

// File: tb/tb_mmio_host_initiator.sv
// tb_mmio_host_initiator: scoreboard bench for mmio_host_initiator (TIMEOUT_CYCLES = 8).
module tb_mmio_host_initiator;
    import ccip_if_pkg::*;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [8:0]  tid;
        logic [63:0] data;
    } rq_t;
    typedef struct {
        logic [63:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_err;
    t_if_ccip_Rx rx;
    t_if_ccip_Tx tx = '0;
`ifdef MMIO_INIT_STATS_EN
    logic [31:0] stat_wr_cnt, stat_rd_cnt;
    logic [15:0] stat_timeout_cnt;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        busy = 1'b0;
    logic [8:0]  tid_m = '0;
    logic [8:0]  t_cur;
    rq_t         rq_q[$];
    exp_t        exp_q[$];
    rq_t         mr;
    exp_t        me;

    mmio_host_initiator #(.TIMEOUT_CYCLES(8), .TID_W(9)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rx(rx), .tx(tx)
`ifdef MMIO_INIT_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_timeout_cnt(stat_timeout_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [15:0] a, input logic [63:0] d);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            step();
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        rq_q.push_back('{wr, a, tid_m, wr ? d : 64'd0});
        if (wr) exp_q.push_back('{64'd0, 1'b0, cyc + 2});
        else tid_m++;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic respond(input int dly, input logic [8:0] t, input logic [63:0] d, input logic good);
        repeat (dly) step();
        tx.c2.mmioRdValid = 1'b1;
        tx.c2.hdr.tid     = t;
        tx.c2.data        = d;
        if (good) exp_q.push_back('{d, 1'b0, cyc + 1});
        step();
        tx = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Request and response monitor
    always @(negedge clk) begin
        if (rst) busy = 1'b0;
        if (busy) chk("ready_while_busy", 64'(cmd_ready), 64'd0);
        if (rx.c0.mmioWrValid || rx.c0.mmioRdValid) begin
            chk("wr_rd_exclusive", 64'(rx.c0.mmioWrValid & rx.c0.mmioRdValid), 64'd0);
            chk("rx_unused_zero", 64'(rx.c0.rspValid | (|rx.c1) | rx.c0TxAlmFull | rx.c1TxAlmFull), 64'd0);
            if (rq_q.size() == 0) chk("rq_unexpected", 64'd1, 64'd0);
            else begin
                mr = rq_q.pop_front();
                chk("rq_kind", 64'(rx.c0.mmioWrValid), 64'(mr.wr));
                chk("rq_addr", 64'(rx.c0.hdr.address), 64'(mr.addr));
                chk("rq_len", 64'(rx.c0.hdr.length), 64'd1);
                chk("rq_tid", 64'(rx.c0.hdr.tid), 64'(mr.tid));
                chk("rq_data", rx.c0.data[63:0], mr.data);
                chk("rq_data_hi", 64'(|rx.c0.data[511:64]), 64'd0);
            end
            if (rx.c0.mmioRdValid) busy = 1'b1;
        end
        if (rsp_valid) begin
            busy = 1'b0;
            if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
            else begin
                me = exp_q.pop_front();
                chk("rsp_data", rsp_data, me.data);
                chk("rsp_err", 64'(rsp_err), 64'(me.err));
                chk("rsp_cycle", 64'(cyc), 64'(me.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_rx", 64'(|rx), 64'd0);
        rst = 1'b0;
        step();

        send(1'b1, 16'h0020, 64'hDEAD_BEEF_0123_4567);
        drain();

        send(1'b0, 16'h0002, 64'd0);
        respond(4, 9'd0, 64'h1122_3344_5566_7788, 1'b1);
        drain();

        send(1'b0, 16'h0010, 64'd0);
        exp_q.push_back('{64'd0, 1'b1, cyc + 9});
        drain();
`ifdef MMIO_INIT_STATS_EN
        chk("stat_timeout", 64'(stat_timeout_cnt), 64'd1);
        chk("stat_rd", 64'(stat_rd_cnt), 64'd2);
        chk("stat_wr", 64'(stat_wr_cnt), 64'd1);
`endif

        send(1'b0, 16'h0011, 64'd0);
        respond(1, 9'd2, 64'h0000_00A2_0000_0002, 1'b1);
        send(1'b0, 16'h0012, 64'd0);
        respond(3, 9'd3, 64'h0000_00A3_0000_0003, 1'b1);
        send(1'b0, 16'h0013, 64'd0);
        respond(8, 9'd4, 64'h0000_00B0_0000_0004, 1'b1);
        drain();

        send(1'b0, 16'h0014, 64'd0);
        respond(1, 9'd4, 64'h0000_0000_0000_0BAD, 1'b0);
        respond(0, 9'd5, 64'h0000_0000_0000_600D, 1'b1);
        drain();

        send(1'b0, 16'h0030, 64'd0);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_rsp_data", rsp_data, 64'd0);
        chk("midrst_rsp_err", 64'(rsp_err), 64'd0);
        chk("midrst_rx", 64'(|rx), 64'd0);
        rst = 1'b0;
        tid_m = '0;
        respond(0, 9'd0, 64'h0000_0000_0000_BEEF, 1'b0);
        repeat (3) step();
        send(1'b1, 16'h0040, 64'h0F0F_0F0F_F0F0_F0F0);
        drain();

        for (int i = 0; i < 513; i++) begin
            t_cur = tid_m;
            send(1'b0, 16'(i), 64'd0);
            respond(1, t_cur, {32'(i), ~32'(i)}, 1'b1);
        end
        drain();
        chk("tid_model_wrapped", 64'(tid_m), 64'd1);
        chk("rq_leftover", 64'(rq_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
